// File: rtl/delta_mask_stream.sv
// Per-pixel |curr-base| magnitude, power-of-two running average, hysteresis mask and
// per-frame motion pixel count. Three register stages, no backpressure.
module delta_mask_stream #(
  parameter int INPUT_WIDTH      = 10,
  parameter int CLOG2_MAX_FILTER = 5,
  parameter int CNT_WIDTH        = 20
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic                   in_eof,
  input  logic [INPUT_WIDTH-1:0] base_frame,
  input  logic [INPUT_WIDTH-1:0] curr_frame,
  input  logic [2:0]             filter_log2,
  input  logic [INPUT_WIDTH-1:0] thr_hi,
  input  logic [INPUT_WIDTH-1:0] thr_lo,
  input  logic                   mode,
  output logic                   out_valid,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic [INPUT_WIDTH-1:0] delta_frame,
  output logic [CNT_WIDTH-1:0]   motion_count,
  output logic                   count_valid
);

  localparam int MAX_LEN = 2**CLOG2_MAX_FILTER;
  localparam int SUM_W   = INPUT_WIDTH + CLOG2_MAX_FILTER;
  localparam int FILL_W  = CLOG2_MAX_FILTER + 1;
  localparam int PTR_W   = CLOG2_MAX_FILTER;

  // Stage 1: absolute difference plus per-beat controls
  logic                   v1_q, sof1_q, eof1_q, mode1_q;
  logic [INPUT_WIDTH-1:0] d1_q, hi1_q, lo1_q;
  logic [2:0]             fl1_q;

  // Stage 2: running sum over circular history
  logic                   v2_q, sof2_q, eof2_q, mode2_q;
  logic [INPUT_WIDTH-1:0] hi2_q, lo2_q;
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic [2:0]             l_q, l_d;
  logic [FILL_W-1:0]      fill_q, fill_d, len;
  logic [PTR_W-1:0]       ptr_q, ptr_d, rd_idx, wr_idx;
  logic [INPUT_WIDTH-1:0] sub;
  logic [INPUT_WIDTH-1:0] hist_q [MAX_LEN];

  // Stage 3: hysteresis, output mux and counter
  logic                   out_valid_q, out_sof_q, out_eof_q, h_q, h_d, h_base;
  logic [INPUT_WIDTH-1:0] delta_q, delta_d, avg, lo_eff;
  logic [SUM_W-1:0]       avg_full;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_base, motion_count_q;
  logic                   count_valid_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      v1_q    <= 1'b0;
      sof1_q  <= 1'b0;
      eof1_q  <= 1'b0;
      mode1_q <= 1'b0;
      d1_q    <= '0;
      hi1_q   <= '0;
      lo1_q   <= '0;
      fl1_q   <= '0;
    end else begin
      v1_q   <= in_valid;
      sof1_q <= in_valid & in_sof;
      eof1_q <= in_valid & in_eof;
      if (in_valid) begin
        d1_q    <= (curr_frame >= base_frame) ? curr_frame - base_frame
                                              : base_frame - curr_frame;
        mode1_q <= mode;
        hi1_q   <= thr_hi;
        lo1_q   <= thr_lo;
        fl1_q   <= filter_log2;
      end
    end
  end

  always_comb begin
    len    = FILL_W'(1) << l_q;
    rd_idx = ptr_q - len[PTR_W-1:0];
    sub    = (fill_q >= len) ? hist_q[rd_idx] : '0;
    l_d    = l_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    ptr_d  = ptr_q;
    wr_idx = ptr_q;
    if (sof1_q) begin
      l_d    = (fl1_q > 3'(CLOG2_MAX_FILTER)) ? 3'(CLOG2_MAX_FILTER) : fl1_q;
      sum_d  = SUM_W'(d1_q);
      fill_d = FILL_W'(1);
      ptr_d  = PTR_W'(1);
      wr_idx = '0;
    end else begin
      // the slot being overwritten at ptr-len is read before this edge's write
      sum_d  = sum_q + SUM_W'(d1_q) - SUM_W'(sub);
      fill_d = (fill_q < len) ? fill_q + FILL_W'(1) : len;
      ptr_d  = ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (v1_q) hist_q[wr_idx] <= d1_q;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      v2_q    <= 1'b0;
      sof2_q  <= 1'b0;
      eof2_q  <= 1'b0;
      mode2_q <= 1'b0;
      hi2_q   <= '0;
      lo2_q   <= '0;
      sum_q   <= '0;
      l_q     <= '0;
      fill_q  <= '0;
      ptr_q   <= '0;
    end else begin
      v2_q   <= v1_q;
      sof2_q <= sof1_q;
      eof2_q <= eof1_q;
      if (v1_q) begin
        mode2_q <= mode1_q;
        hi2_q   <= hi1_q;
        lo2_q   <= lo1_q;
        sum_q   <= sum_d;
        l_q     <= l_d;
        fill_q  <= fill_d;
        ptr_q   <= ptr_d;
      end
    end
  end

  always_comb begin
    avg_full = sum_q >> l_q;
    avg      = avg_full[INPUT_WIDTH-1:0];
    lo_eff   = (lo2_q > hi2_q) ? hi2_q : lo2_q;
    h_base   = sof2_q ? 1'b0 : h_q;
    h_d      = h_base;
    if (avg > hi2_q)       h_d = 1'b1;
    else if (avg < lo_eff) h_d = 1'b0;
    cnt_base = sof2_q ? '0 : cnt_q;
    cnt_d    = (h_d && !(&cnt_base)) ? cnt_base + CNT_WIDTH'(1) : cnt_base;
    delta_d  = mode2_q ? avg : {INPUT_WIDTH{h_d}};
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid_q    <= 1'b0;
      out_sof_q      <= 1'b0;
      out_eof_q      <= 1'b0;
      delta_q        <= '0;
      h_q            <= 1'b0;
      cnt_q          <= '0;
      motion_count_q <= '0;
      count_valid_q  <= 1'b0;
    end else begin
      out_valid_q   <= v2_q;
      out_sof_q     <= sof2_q;
      out_eof_q     <= eof2_q;
      delta_q       <= v2_q ? delta_d : '0;
      count_valid_q <= out_valid_q & out_eof_q;
      if (v2_q) begin
        h_q   <= h_d;
        cnt_q <= cnt_d;
      end
      if (out_valid_q && out_eof_q) motion_count_q <= cnt_q;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_sof      = out_sof_q;
  assign out_eof      = out_eof_q;
  assign delta_frame  = delta_q;
  assign motion_count = motion_count_q;
  assign count_valid  = count_valid_q;

endmodule

// File: tb/tb_delta_mask_stream.sv
// Scoreboard bench for delta_mask_stream: directed beats push hand-computed expectations,
// a negedge monitor pops and compares output beats, latency and per-frame counts.
module tb_delta_mask_stream;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        in_valid, in_sof, in_eof, mode;
  logic [9:0]  base_frame, curr_frame, thr_hi, thr_lo;
  logic [2:0]  filter_log2;
  logic        out_valid, out_sof, out_eof, count_valid;
  logic [9:0]  delta_frame;
  logic [19:0] motion_count;

  always #5 clk = ~clk;

  delta_mask_stream dut (
    .clk(clk), .aresetn(aresetn), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .base_frame(base_frame), .curr_frame(curr_frame), .filter_log2(filter_log2),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .mode(mode),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .delta_frame(delta_frame), .motion_count(motion_count), .count_valid(count_valid)
  );

  typedef struct {bit sof; bit eof; int d;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   cnt_exp_q[$];
  int   in_t_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   cv_pending = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && aresetn) in_t_q.push_back(cyc);
  end

  always @(negedge clk) begin
    if (cv_pending) begin
      chk("count_valid", count_valid, 1);
      if (cnt_exp_q.size() == 0) chk("count_expected_avail", cnt_exp_q.size(), 1);
      else chk("motion_count", motion_count, cnt_exp_q.pop_front());
      cv_pending = 1'b0;
    end else if (count_valid) begin
      chk("count_valid_spurious", count_valid, 0);
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("delta_frame", delta_frame, e.d);
        chk("out_sof", out_sof, e.sof);
        chk("out_eof", out_eof, e.eof);
        if (e.eof) cv_pending = 1'b1;
      end
      if (in_t_q.size() > 0) chk("latency", cyc - in_t_q.pop_front(), 3);
    end
  end

  task automatic beat(input bit s, input bit eo, input int b, input int c, input int exp_d,
                      input int gap);
    exp_t x;
    x.sof = s; x.eof = eo; x.d = exp_d;
    exp_q.push_back(x);
    in_sof = s; in_eof = eo;
    base_frame = 10'(b); curr_frame = 10'(c);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sof"}, out_sof, 0);
    chk({tag, "_out_eof"}, out_eof, 0);
    chk({tag, "_delta"}, delta_frame, 0);
    chk({tag, "_motion_count"}, motion_count, 0);
    chk({tag, "_count_valid"}, count_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  int t6_d   [16] = '{0, 0, 200, 0, 0, 0, 0, 0, 200, 80, 0, 0, 200, 200, 0, 0};
  int t6_m   [16] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0};
  int t5_exp [6]  = '{5, 15, 25, 35, 45, 55};

  initial begin
    aresetn = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; mode = 1'b0;
    base_frame = '0; curr_frame = '0; thr_hi = '0; thr_lo = '0; filter_log2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    aresetn = 1'b1;
    idle(2);

    // T2 step response, L=2; later filter_log2 changes must be ignored
    filter_log2 = 3'd2; mode = 1'b1; thr_hi = 10'd1023; thr_lo = 10'd0;
    beat(1, 0, 0, 100, 25, 0);
    filter_log2 = 3'd0;
    beat(0, 0, 0, 100, 50, 0);
    beat(0, 0, 0, 100, 75, 0);
    beat(0, 0, 0, 100, 100, 0);
    beat(0, 0, 0, 100, 100, 0);
    cnt_exp_q.push_back(0);
    beat(0, 1, 0, 100, 100, 0);
    idle(4);

    // T3 window wrap, filter_log2=7 clamps to 5
    filter_log2 = 3'd7;
    cnt_exp_q.push_back(0);
    for (int i = 0; i < 40; i++)
      beat(i == 0, i == 39, 0, (i % 2) ? 64 : 0, (i < 32) ? 2 * ((i + 1) / 2) : 32, 0);
    idle(4);

    // T4 hysteresis, then thr_lo above thr_hi
    filter_log2 = 3'd0; mode = 1'b0; thr_hi = 10'd60; thr_lo = 10'd40;
    beat(1, 0, 0, 30, 0, 0);
    beat(0, 0, 100, 30, 1023, 0);
    beat(0, 0, 50, 0, 1023, 0);
    beat(0, 0, 0, 35, 0, 0);
    thr_lo = 10'd80;
    beat(0, 0, 0, 61, 1023, 0);
    beat(0, 0, 0, 60, 1023, 0);
    beat(0, 0, 0, 59, 0, 0);
    beat(0, 0, 0, 60, 0, 0);
    cnt_exp_q.push_back(5);
    beat(0, 1, 0, 100, 1023, 0);
    idle(4);

    // T5 blanking gaps inside a frame, L=1
    filter_log2 = 3'd1; mode = 1'b1; thr_hi = 10'd1023; thr_lo = 10'd0;
    cnt_exp_q.push_back(0);
    for (int i = 0; i < 6; i++)
      beat(i == 0, i == 5, 0, 10 * (i + 1), t5_exp[i], $urandom_range(0, 7));
    idle(4);

    // T6 4x4 frame with five mask pixels, then single-pixel frames
    filter_log2 = 3'd0; mode = 1'b0; thr_hi = 10'd100; thr_lo = 10'd50;
    cnt_exp_q.push_back(5);
    for (int i = 0; i < 16; i++)
      beat(i == 0, i == 15, 0, t6_d[i], t6_m[i] ? 1023 : 0, 0);
    idle(3);
    cnt_exp_q.push_back(1);
    beat(1, 1, 0, 200, 1023, 2);
    cnt_exp_q.push_back(0);
    beat(1, 1, 0, 80, 0, 2);
    cnt_exp_q.push_back(1);
    beat(1, 1, 0, 200, 1023, 2);
    idle(6);

    // T1 mid-stream reset with beats in flight, then resume on a new sof
    mode = 1'b1; thr_hi = 10'd1023; thr_lo = 10'd0;
    beat(1, 0, 0, 500, 500, 0);
    beat(0, 0, 0, 500, 500, 0);
    beat(0, 0, 0, 500, 500, 0);
    beat(0, 0, 0, 500, 500, 0);
    aresetn = 1'b0;
    exp_q.delete();
    in_t_q.delete();
    cv_pending = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    aresetn = 1'b1;
    idle(1);
    beat(1, 0, 0, 7, 7, 0);
    beat(0, 0, 9, 0, 9, 1);
    cnt_exp_q.push_back(0);
    beat(0, 1, 20, 25, 5, 0);

    begin
      int w;
      w = 0;
      while ((exp_q.size() != 0 || cnt_exp_q.size() != 0 || cv_pending) && w < 100) begin
        @(posedge clk);
        w++;
      end
      chk("drain_pending", exp_q.size() + cnt_exp_q.size() + int'(cv_pending), 0);
    end
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
